// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: state encoding, opcodes, response bytes and frame slot indices
package uart_cmd_pkg;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_LATCH = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_EXEC  = 4'd4;
  localparam logic [3:0] S_LUTRD = 4'd5;
  localparam logic [3:0] S_ACK   = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_NAK   = 4'd8;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] CMD_EN  = 8'h03;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [2:0] SLOT_HDR  = 3'd0;
  localparam logic [2:0] SLOT_CMD  = 3'd1;
  localparam logic [2:0] SLOT_ADDR = 3'd2;
  localparam logic [2:0] SLOT_DATA = 3'd3;
  localparam logic [2:0] SLOT_CHK  = 3'd4;
endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte timeout counter, counts while run, expires at TIMEOUTCYCLE-1
module uart_cmd_timeout #(
  parameter int TIMEOUTCYCLE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(TIMEOUTCYCLE + 1);
  logic [W-1:0] cnt;
  assign expire = run && cnt == W'(TIMEOUTCYCLE - 1);
  // count idle gap cycles; restart on every latched byte and after expiry
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr || expire) cnt <= '0;
    else if (run) cnt <= cnt + W'(1);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: pops 5-byte frames from the RX FIFO, runs LUT/gamma commands, pushes ACK/NAK
import uart_cmd_pkg::*;
module uart_cmd_ctrl #(
  parameter int PACKAGESIZE = 8,
  parameter int LUTADDRBIT = 8,
  parameter int LUTDATABIT = 8,
  parameter logic [PACKAGESIZE-1:0] HEADER = 8'hA5,
  parameter int TIMEOUTCYCLE = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKAGESIZE-1:0] rxFifoData,
  input  logic                   rxFifoEmpty,
  output logic                   rxFifoRead,
  input  logic [1:0]             rxError,
  output logic [PACKAGESIZE-1:0] txFifoData,
  input  logic                   txFifoFull,
  output logic                   txFifoWrite,
  output logic [LUTADDRBIT-1:0]  lutAddr,
  output logic [LUTDATABIT-1:0]  lutWrData,
  output logic                   lutWrite,
  output logic                   lutRead,
  input  logic [LUTDATABIT-1:0]  lutRdData,
  output logic                   gammaEnable,
  output logic                   busy,
  output logic [7:0]             errCount
);
  logic [3:0] state, state_nxt;
  logic [2:0] byte_idx;
  logic [PACKAGESIZE-1:0] cmd_q, addr_q, data_q, chk_q;
  logic [LUTDATABIT-1:0] rd_q;
  logic expire, tmr_run, frame_ok, is_rd;
  assign is_rd = cmd_q == CMD_RD;
  assign tmr_run = state == S_IDLE && byte_idx != SLOT_HDR && rxFifoEmpty;
  assign frame_ok = (cmd_q ^ addr_q ^ data_q) == chk_q && (cmd_q == CMD_WR || is_rd || cmd_q == CMD_EN);
  uart_cmd_timeout #(.TIMEOUTCYCLE(TIMEOUTCYCLE)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(state == S_LATCH),
    .run(tmr_run),
    .expire(expire)
  );
  // next-state: response states hold until the TX FIFO can take the byte
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = expire ? S_NAK : !rxFifoEmpty ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = rxError != 2'b0 ? S_NAK : byte_idx == SLOT_CHK ? S_CHECK : S_IDLE;
      S_CHECK: state_nxt = frame_ok ? S_EXEC : S_NAK;
      S_EXEC:  state_nxt = is_rd ? S_LUTRD : S_ACK;
      S_LUTRD: state_nxt = S_ACK;
      S_ACK:   state_nxt = txFifoFull ? S_ACK : is_rd ? S_RDATA : S_IDLE;
      S_RDATA: state_nxt = txFifoFull ? S_RDATA : S_IDLE;
      S_NAK:   state_nxt = txFifoFull ? S_NAK : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  // frame capture, slot tracking, command side effects and error counting
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      byte_idx <= SLOT_HDR;
      cmd_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      chk_q <= '0;
      rd_q <= '0;
      gammaEnable <= 1'b0;
      errCount <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_LATCH) begin
        if (byte_idx == SLOT_CMD) cmd_q <= rxFifoData;
        if (byte_idx == SLOT_ADDR) addr_q <= rxFifoData;
        if (byte_idx == SLOT_DATA) data_q <= rxFifoData;
        if (byte_idx == SLOT_CHK) chk_q <= rxFifoData;
        byte_idx <= (rxError != 2'b0 || byte_idx == SLOT_CHK) ? SLOT_HDR :
                    (byte_idx == SLOT_HDR && rxFifoData != HEADER) ? SLOT_HDR : byte_idx + 3'd1;
      end
      if (expire) byte_idx <= SLOT_HDR;
      if (state == S_LUTRD) rd_q <= lutRdData;
      if (state == S_EXEC && cmd_q == CMD_EN) gammaEnable <= data_q[0];
      if (state == S_NAK && !txFifoFull && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  assign rxFifoRead = state == S_FETCH;
  assign lutWrite = state == S_EXEC && cmd_q == CMD_WR;
  assign lutRead = state == S_EXEC && is_rd;
  assign lutAddr = LUTADDRBIT'(addr_q);
  assign lutWrData = LUTDATABIT'(data_q);
  assign txFifoWrite = (state == S_ACK || state == S_RDATA || state == S_NAK) && !txFifoFull;
  assign txFifoData = state == S_ACK ? PACKAGESIZE'(RSP_ACK) :
                      state == S_NAK ? PACKAGESIZE'(RSP_NAK) :
                      state == S_RDATA ? PACKAGESIZE'(rd_q) : '0;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: frame-level model with per-cycle scoreboard for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int TMO = 40;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rxFifoData = 8'h00;
  logic rxFifoEmpty = 1'b1;
  logic rxFifoRead;
  logic [1:0] rxError = 2'b00;
  logic [7:0] txFifoData;
  logic txFifoFull = 1'b0;
  logic txFifoWrite;
  logic [7:0] lutAddr, lutWrData;
  logic lutWrite, lutRead;
  logic [7:0] lutRdData = 8'h00;
  logic gammaEnable, busy;
  logic [7:0] errCount;

  uart_cmd_ctrl #(.TIMEOUTCYCLE(TMO)) dut (
    .clk(clk), .rst(rst), .rxFifoData(rxFifoData), .rxFifoEmpty(rxFifoEmpty),
    .rxFifoRead(rxFifoRead), .rxError(rxError), .txFifoData(txFifoData),
    .txFifoFull(txFifoFull), .txFifoWrite(txFifoWrite), .lutAddr(lutAddr),
    .lutWrData(lutWrData), .lutWrite(lutWrite), .lutRead(lutRead),
    .lutRdData(lutRdData), .gammaEnable(gammaEnable), .busy(busy), .errCount(errCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fetch = 0;
  int last_tx = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_tx = 0;
  logic [15:0] last_wr = 16'h0;
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_log[$];
  logic [7:0] m_frame[5];
  int m_slot = 0;
  int m_err = 0;
  logic m_gamma = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_nak();
    exp_tx.push_back(8'h15);
    if (m_err < 255) m_err++;
  endtask

  // spec-level frame parser: decides the responses a byte stream must produce
  task automatic model_byte(input logic [7:0] b, input bit err);
    logic [7:0] c, a, d;
    if (err) begin
      m_nak();
      m_slot = 0;
    end else if (!(m_slot == 0 && b != 8'hA5)) begin
      m_frame[m_slot] = b;
      m_slot++;
      if (m_slot == 5) begin
        m_slot = 0;
        c = m_frame[1];
        a = m_frame[2];
        d = m_frame[3];
        if ((c ^ a ^ d) != m_frame[4] || c < 8'd1 || c > 8'd3) m_nak();
        else begin
          if (c == 8'd1) exp_wr.push_back({a, d});
          if (c == 8'd3) m_gamma = d[0];
          exp_tx.push_back(8'h06);
          if (c == 8'd2) begin
            exp_rd.push_back(a);
            exp_tx.push_back(a ^ 8'h67);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rxq.push_back(b);
    model_byte(b, rxError != 2'b00);
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (k < bound && !(rxq.size() == 0 && exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 && !busy));
    chk("drain_done", k < bound, 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic scen_check();
    chk("gamma_model", gammaEnable, m_gamma);
    chk("errcount_model", errCount, m_err);
    chk("idle_busy", busy, 0);
  endtask

  // per-cycle environment (RX FIFO, LUT) and scoreboard compare
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rxFifoRead) begin
      last_fetch = cyc;
      chk("pop_nonempty", rxq.size() != 0, 1);
      if (rxq.size() != 0) rxFifoData = rxq.pop_front();
    end
    rxFifoEmpty = rxq.size() == 0;
    chk("strobe_excl", lutWrite & lutRead, 0);
    chk("tx_while_full", txFifoWrite & txFifoFull, 0);
    if (lutWrite) begin
      n_wr++;
      last_wr = {lutAddr, lutWrData};
      chk("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) chk("wr_addr_data", {lutAddr, lutWrData}, exp_wr.pop_front());
    end
    if (lutRead) begin
      n_rd++;
      lutRdData = lutAddr ^ 8'h67;
      chk("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("rd_addr", lutAddr, exp_rd.pop_front());
    end
    if (txFifoWrite) begin
      n_tx++;
      last_tx = cyc;
      tx_log.push_back(txFifoData);
      chk("tx_expected", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) chk("tx_byte", txFifoData, exp_tx.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_strobes", {rxFifoRead, txFifoWrite, lutWrite, lutRead, gammaEnable, busy}, 0);
    chk("rst_errcount", errCount, 0);
    chk("rst_txdata", txFifoData, 0);
    rst = 1'b1;
    // LUT write
    send5(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    drain(200);
    chk("wr_count_lit", n_wr, 1);
    chk("wr_lit", last_wr, 16'h103C);
    chk("ack_lit", tx_log[tx_log.size() - 1], 8'h06);
    chk("ack_latency", last_tx - last_fetch, 4);
    scen_check();
    // LUT read
    send5(8'hA5, 8'h02, 8'h10, 8'h00, 8'h12);
    drain(200);
    chk("rd_count_lit", n_rd, 1);
    chk("rd_ack_lit", tx_log[tx_log.size() - 2], 8'h06);
    chk("rd_data_lit", tx_log[tx_log.size() - 1], 8'h77);
    scen_check();
    // gamma enable, then a bad checksum
    send5(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
    drain(200);
    chk("gamma_lit", gammaEnable, 1);
    chk("en_no_lut", n_wr + n_rd, 2);
    send5(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00);
    drain(200);
    chk("badchk_no_wr", n_wr, 1);
    chk("nak_lit", tx_log[tx_log.size() - 1], 8'h15);
    chk("err_lit", errCount, 1);
    scen_check();
    // junk bytes before a valid header are dropped silently
    send5(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03);
    drain(200);
    chk("gamma_off", gammaEnable, 0);
    t0 = n_tx;
    send(8'h00);
    send(8'hFF);
    send5(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
    drain(200);
    chk("junk_single_ack", n_tx - t0, 1);
    chk("junk_gamma", gammaEnable, 1);
    scen_check();
    // inter-byte timeout
    send(8'hA5);
    send(8'h01);
    m_nak();
    m_slot = 0;
    drain(TMO + 100);
    chk("tmo_window", (last_tx - last_fetch >= TMO) && (last_tx - last_fetch <= TMO + 3), 1);
    chk("tmo_nak_lit", tx_log[tx_log.size() - 1], 8'h15);
    scen_check();
    send5(8'hA5, 8'h01, 8'h20, 8'h55, 8'h74);
    drain(200);
    chk("after_tmo_wr", last_wr, 16'h2055);
    scen_check();
    // TX back-pressure during a read
    t0 = n_tx;
    txFifoFull = 1'b1;
    send5(8'hA5, 8'h02, 8'h33, 8'h00, 8'h31);
    repeat (20) @(negedge clk);
    chk("held_while_full", n_tx - t0, 0);
    txFifoFull = 1'b0;
    drain(200);
    chk("bp_ack_lit", tx_log[tx_log.size() - 2], 8'h06);
    chk("bp_data_lit", tx_log[tx_log.size() - 1], 8'h54);
    scen_check();
    // receiver error aborts
    rxError = 2'b01;
    send(8'hA5);
    drain(200);
    rxError = 2'b00;
    scen_check();
    // errCount saturation
    rxError = 2'b10;
    for (int i = 0; i < 260; i++) send(8'h00);
    drain(3000);
    rxError = 2'b00;
    chk("err_sat_lit", errCount, 8'hFF);
    scen_check();
    // reset mid-frame
    send(8'hA5);
    send(8'h01);
    send(8'h10);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_strobes", {rxFifoRead, txFifoWrite, lutWrite, lutRead, gammaEnable, busy}, 0);
    chk("midrst_err", errCount, 0);
    chk("midrst_bus", {txFifoData, lutAddr, lutWrData}, 0);
    rxq.delete();
    m_slot = 0;
    m_err = 0;
    m_gamma = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send5(8'hA5, 8'h01, 8'h44, 8'h99, 8'hDC);
    drain(200);
    chk("post_rst_wr", last_wr, 16'h4499);
    scen_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
